// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RV32I controller.
//   state_t      : 5-bit FSM state encoding, which is also exported on the debug port
//   OPC_*        : RV32I major opcodes that the controller dispatches on
//   ALU_*        : ALUControl encoding understood by the datapath ALU
//   ALUOP_*      : coarse ALU operation class that the FSM hands to alu_op_decoder
package mc_pkg;

    typedef enum logic [4:0] {
        FETCH     = 5'd0,
        DECODE    = 5'd1,
        MEM_ADDR  = 5'd2,
        MEM_READ  = 5'd3,
        MEM_WRITE = 5'd4,
        WRITEBACK = 5'd5,
        ALU_WB    = 5'd6,
        EXEC_R    = 5'd7,
        EXEC_I    = 5'd8,
        JAL       = 5'd9,
        JALR      = 5'd10,
        JALR_LINK = 5'd11,
        BRANCH    = 5'd12,
        AUIPC     = 5'd13,
        LUI       = 5'd14,
        FAULT     = 5'd15
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // States that hold a memory request open and therefore run the wait counter.
    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Bundle between the control FSM and the datapath/memory.
//   master : controller side (samples IR, ALU flags, mem_ready; drives strobes/muxes)
//   slave  : datapath side (the reverse directions)
interface mc_controller_if;
    logic [31:0] instruction;
    logic        zero;
    logic        negative;
    logic        overflow;
    logic        carry;
    logic        mem_ready;

    logic        pc_write;
    logic        AdrSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrca;
    logic [1:0]  ALUSrcb;
    logic [3:0]  ALUControl;
    logic [2:0]  mem_size;
    logic        illegal;
    logic        mem_fault;
    logic [4:0]  state;

    modport master (
        input  instruction, zero, negative, overflow, carry, mem_ready,
        output pc_write, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrca, ALUSrcb, ALUControl, mem_size,
               illegal, mem_fault, state
    );

    modport slave (
        output instruction, zero, negative, overflow, carry, mem_ready,
        input  pc_write, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrca, ALUSrcb, ALUControl, mem_size,
               illegal, mem_fault, state
    );
endinterface

// File: rtl/mc_controller_alu_op_decoder.sv
// Combinational ALU decoder.
//   alu_op      : class requested by the FSM (add / sub / decode from funct fields)
//   funct3      : instruction[14:12]
//   funct7b5    : instruction[30]
//   opb5        : instruction[5]; distinguishes register ops from immediate ops
//   alu_control : ALU operation select
module alu_op_decoder
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       opb5,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Bit 30 is an immediate bit for addi, so SUB also needs a register op.
                    3'b000:  alu_control = (funct7b5 && opb5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM with variable-latency memory.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : mc_controller_if.master -- IR, ALU flags and mem_ready in;
//                datapath strobes, mux selects, ALUControl, mem_size,
//                sticky illegal/mem_fault flags and debug state out
// Memory states hold their request until mem_ready; a wait counter forces a
// FAULT after MEM_TIMEOUT unanswered cycles. FAULT is absorbing until reset.
module mc_controller
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMEOUT_W   = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);

    state_t                 state_reg, state_next;
    logic [TIMEOUT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic                   illegal_reg, illegal_next;
    logic                   mem_fault_reg, mem_fault_next;

    logic [TIMEOUT_W-1:0]   wait_inc;
    logic                   timeout;
    logic [1:0]             alu_op;
    logic                   branch_taken;
    logic                   branch_legal;

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = bus.instruction[6:0];
    assign funct3 = bus.instruction[14:12];

    // Counter only advances while waiting, so it never exceeds MEM_TIMEOUT.
    assign wait_inc = wait_cnt_reg + 1'b1;
    assign timeout  = (wait_inc == TIMEOUT_W'(MEM_TIMEOUT));

    alu_op_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (bus.instruction[30]),
        .opb5        (bus.instruction[5]),
        .alu_control (bus.ALUControl)
    );

    // Flags come from rs1 - rs2; carry=1 means no borrow, i.e. rs1 >= rs2 unsigned.
    always_comb begin
        branch_taken = 1'b0;
        branch_legal = 1'b1;
        case (funct3)
            3'b000:  branch_taken = bus.zero;
            3'b001:  branch_taken = !bus.zero;
            3'b100:  branch_taken = bus.negative ^ bus.overflow;
            3'b101:  branch_taken = !(bus.negative ^ bus.overflow);
            3'b110:  branch_taken = !bus.carry;
            3'b111:  branch_taken = bus.carry;
            default: branch_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= FETCH;
            wait_cnt_reg  <= '0;
            illegal_reg   <= 1'b0;
            mem_fault_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            illegal_reg   <= illegal_next;
            mem_fault_reg <= mem_fault_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        illegal_next   = illegal_reg;
        mem_fault_next = mem_fault_reg;
        alu_op         = ALUOP_ADD;
        bus.pc_write   = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrca    = 2'b00;
        bus.ALUSrcb    = 2'b00;
        bus.mem_size   = 3'b000;

        // Every non-memory state leaves the counter at zero, so entering a
        // memory state always starts a fresh count.
        if (is_mem_state(state_reg) && !bus.mem_ready)
            wait_cnt_next = wait_inc;
        else if (state_reg == FAULT)
            wait_cnt_next = wait_cnt_reg;
        else
            wait_cnt_next = '0;

        case (state_reg)
            FETCH: begin
                bus.MemRead   = 1'b1;
                bus.ALUSrcb   = 2'b10;
                bus.ResultSrc = 2'b10;
                if (bus.mem_ready) begin
                    bus.IRWrite  = 1'b1;
                    bus.pc_write = 1'b1;
                    state_next   = DECODE;
                end else if (timeout) begin
                    state_next     = FAULT;
                    mem_fault_next = 1'b1;
                end
            end
            DECODE: begin
                bus.ALUSrca = 2'b01;
                bus.ALUSrcb = 2'b01;
                case (opcode)
                    OPC_LOAD, OPC_STORE: state_next = MEM_ADDR;
                    OPC_OP:              state_next = EXEC_R;
                    OPC_OP_IMM:          state_next = EXEC_I;
                    OPC_JAL:             state_next = JAL;
                    OPC_JALR:            state_next = JALR;
                    OPC_BRANCH:          state_next = BRANCH;
                    OPC_AUIPC:           state_next = AUIPC;
                    OPC_LUI:             state_next = LUI;
                    default: begin
                        state_next   = FAULT;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                bus.ALUSrca = 2'b10;
                bus.ALUSrcb = 2'b01;
                state_next  = (opcode == OPC_LOAD) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                bus.AdrSrc   = 1'b1;
                bus.MemRead  = 1'b1;
                bus.mem_size = funct3;
                if (bus.mem_ready) begin
                    state_next = WRITEBACK;
                end else if (timeout) begin
                    state_next     = FAULT;
                    mem_fault_next = 1'b1;
                end
            end
            MEM_WRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                bus.mem_size = funct3;
                if (bus.mem_ready) begin
                    state_next = FETCH;
                end else if (timeout) begin
                    state_next     = FAULT;
                    mem_fault_next = 1'b1;
                end
            end
            WRITEBACK: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
                state_next    = FETCH;
            end
            ALU_WB: begin
                bus.RegWrite = 1'b1;
                state_next   = FETCH;
            end
            EXEC_R: begin
                bus.ALUSrca = 2'b10;
                alu_op      = ALUOP_FUNCT;
                state_next  = ALU_WB;
            end
            EXEC_I: begin
                bus.ALUSrca = 2'b10;
                bus.ALUSrcb = 2'b01;
                alu_op      = ALUOP_FUNCT;
                state_next  = ALU_WB;
            end
            JAL: begin
                // PC takes the target computed in DECODE; ALU forms the link value.
                bus.pc_write = 1'b1;
                bus.ALUSrca  = 2'b01;
                bus.ALUSrcb  = 2'b10;
                state_next   = ALU_WB;
            end
            JALR: begin
                bus.ALUSrca   = 2'b10;
                bus.ALUSrcb   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.pc_write  = 1'b1;
                state_next    = JALR_LINK;
            end
            JALR_LINK: begin
                bus.ALUSrca = 2'b01;
                bus.ALUSrcb = 2'b10;
                state_next  = ALU_WB;
            end
            BRANCH: begin
                bus.ALUSrca = 2'b10;
                alu_op      = ALUOP_SUB;
                if (branch_legal) begin
                    bus.pc_write = branch_taken;
                    state_next   = FETCH;
                end else begin
                    state_next   = FAULT;
                    illegal_next = 1'b1;
                end
            end
            AUIPC: begin
                bus.ALUSrca = 2'b01;
                bus.ALUSrcb = 2'b01;
                state_next  = ALU_WB;
            end
            LUI: begin
                bus.ALUSrca = 2'b11;
                bus.ALUSrcb = 2'b01;
                state_next  = ALU_WB;
            end
            FAULT: state_next = FAULT;
            default: state_next = FAULT;
        endcase
    end

    assign bus.illegal   = illegal_reg;
    assign bus.mem_fault = mem_fault_reg;
    assign bus.state     = state_reg;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: table of per-cycle vectors for the normal
// instruction flows, plus hand-built sequences for timeouts, traps and reset.
module tb_mc_controller;
    import mc_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_controller_if bus();

    mc_controller #(.MEM_TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic        rdy;
        logic [3:0]  flg;   // {zero, negative, overflow, carry}
        state_t      st;
        logic [5:0]  strb;  // {pc_write, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite}
        logic [5:0]  mux;   // {ResultSrc, ALUSrca, ALUSrcb}
        logic [3:0]  alu;
        logic [2:0]  sz;
        logic [1:0]  flt;   // {illegal, mem_fault}
    } vec_t;

    localparam logic [5:0] SB_NONE = 6'b000000;
    localparam logic [5:0] SB_FRDY = 6'b101010;
    localparam logic [5:0] SB_FWT  = 6'b001000;
    localparam logic [5:0] SB_RW   = 6'b000001;
    localparam logic [5:0] SB_MR   = 6'b011000;
    localparam logic [5:0] SB_MW   = 6'b010100;
    localparam logic [5:0] SB_PC   = 6'b100000;

    localparam logic [5:0] MX_ZERO  = 6'b000000;
    localparam logic [5:0] MX_FETCH = 6'b100010;
    localparam logic [5:0] MX_DEC   = 6'b000101;
    localparam logic [5:0] MX_R     = 6'b001000;
    localparam logic [5:0] MX_I     = 6'b001001;
    localparam logic [5:0] MX_WB    = 6'b010000;
    localparam logic [5:0] MX_LUI   = 6'b001101;
    localparam logic [5:0] MX_JALR  = 6'b101001;
    localparam logic [5:0] MX_LINK  = 6'b000110;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_OR   = 32'h0020E1B3;
    localparam logic [31:0] I_SRAI = 32'h4010D093;
    localparam logic [31:0] I_LW   = 32'h0000A283;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BLTU = 32'h0020E063;
    localparam logic [31:0] I_BGEU = 32'h0020F063;
    localparam logic [31:0] I_BLT  = 32'h0020C063;
    localparam logic [31:0] I_BGE  = 32'h0020D063;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_B010 = 32'h0020A063;
    localparam logic [31:0] I_LUI  = 32'h123452B7;
    localparam logic [31:0] I_JALR = 32'h000100E7;
    localparam logic [31:0] I_JAL  = 32'h000000EF;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t row(input logic [31:0] instr, input logic rdy, input logic [3:0] flg,
                                 input state_t st, input logic [5:0] strb, input logic [5:0] mux,
                                 input logic [3:0] alu, input logic [2:0] sz, input logic [1:0] flt);
        vec_t v;
        v.instr = instr; v.rdy = rdy; v.flg = flg; v.st = st; v.strb = strb;
        v.mux = mux; v.alu = alu; v.sz = sz; v.flt = flt;
        return v;
    endfunction

    // Called just after a falling edge: drive, check, then advance to the next falling edge.
    task automatic apply(input vec_t v, input string tag, input int idx);
        logic [5:0] strb_got;
        logic [5:0] mux_got;
        logic [1:0] flt_got;
        bus.instruction = v.instr;
        bus.mem_ready   = v.rdy;
        {bus.zero, bus.negative, bus.overflow, bus.carry} = v.flg;
        #1;
        strb_got = {bus.pc_write, bus.AdrSrc, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite};
        mux_got  = {bus.ResultSrc, bus.ALUSrca, bus.ALUSrcb};
        flt_got  = {bus.illegal, bus.mem_fault};
        checks++;
        if (bus.state !== 5'(v.st) || strb_got !== v.strb || mux_got !== v.mux ||
            bus.ALUControl !== v.alu || bus.mem_size !== v.sz || flt_got !== v.flt) begin
            errors++;
            $display("FAIL %s[%0d]: got st=%0d strb=%b mux=%b alu=%0d sz=%b flt=%b, want st=%0d strb=%b mux=%b alu=%0d sz=%b flt=%b",
                     tag, idx, bus.state, strb_got, mux_got, bus.ALUControl, bus.mem_size, flt_got,
                     v.st, v.strb, v.mux, v.alu, v.sz, v.flt);
        end else begin
            $display("ok   %s[%0d]: st=%0d strb=%b mux=%b alu=%0d", tag, idx, bus.state, strb_got, mux_got, bus.ALUControl);
        end
        @(negedge clk);
    endtask

    // Assert reset between edges and verify state/flags clear before any clock edge.
    task automatic async_reset_check(input string tag);
        #3;
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.state !== 5'(FETCH) || bus.illegal !== 1'b0 || bus.mem_fault !== 1'b0 || bus.MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL %s: got st=%0d illegal=%b mem_fault=%b MemWrite=%b, want st=0 illegal=0 mem_fault=0 MemWrite=0",
                     tag, bus.state, bus.illegal, bus.mem_fault, bus.MemWrite);
        end else begin
            $display("ok   %s: st=%0d flags cleared", tag, bus.state);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.instruction = 32'h0;
        bus.mem_ready   = 1'b0;
        {bus.zero, bus.negative, bus.overflow, bus.carry} = 4'b0000;

        // Reset state while reset is held.
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 5'(FETCH) || bus.illegal !== 1'b0 || bus.mem_fault !== 1'b0 ||
            bus.MemWrite !== 1'b0 || bus.AdrSrc !== 1'b0 || bus.IRWrite !== 1'b0) begin
            errors++;
            $display("FAIL reset: got st=%0d illegal=%b mem_fault=%b MemWrite=%b AdrSrc=%b IRWrite=%b, want FETCH and zeros",
                     bus.state, bus.illegal, bus.mem_fault, bus.MemWrite, bus.AdrSrc, bus.IRWrite);
        end else begin
            $display("ok   reset: st=%0d", bus.state);
        end
        @(negedge clk);
        reset = 1'b0;

        // FETCH never answered: 16 waiting cycles, then FAULT with mem_fault.
        for (int i = 0; i < 16; i++)
            apply(row(I_ADD, 1'b0, 4'b0000, FETCH, SB_FWT, MX_FETCH, ALU_ADD, 3'b000, 2'b00), "fetch_to", i);
        apply(row(I_ADD, 1'b0, 4'b0000, FAULT, SB_NONE, MX_ZERO, ALU_ADD, 3'b000, 2'b01), "fetch_to", 16);
        apply(row(I_ADD, 1'b1, 4'b0000, FAULT, SB_NONE, MX_ZERO, ALU_ADD, 3'b000, 2'b01), "fetch_to", 17);
        async_reset_check("rst_mem_fault");

        // Normal instruction flows, one row per cycle.
        vecs.push_back(row(I_ADD, 1'b1, 4'b0000, FETCH,  SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_ADD, 1'b1, 4'b0000, DECODE, SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_ADD, 1'b1, 4'b0000, EXEC_R, SB_NONE, MX_R,     ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_ADD, 1'b1, 4'b0000, ALU_WB, SB_RW,   MX_ZERO,  ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_SUB, 1'b1, 4'b0000, FETCH,  SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_SUB, 1'b1, 4'b0000, DECODE, SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_SUB, 1'b1, 4'b0000, EXEC_R, SB_NONE, MX_R,     ALU_SUB, 3'b000, 2'b00));
        vecs.push_back(row(I_SUB, 1'b1, 4'b0000, ALU_WB, SB_RW,   MX_ZERO,  ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_OR,  1'b1, 4'b0000, FETCH,  SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_OR,  1'b1, 4'b0000, DECODE, SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_OR,  1'b1, 4'b0000, EXEC_R, SB_NONE, MX_R,     ALU_OR,  3'b000, 2'b00));
        vecs.push_back(row(I_OR,  1'b1, 4'b0000, ALU_WB, SB_RW,   MX_ZERO,  ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_SRAI, 1'b1, 4'b0000, FETCH,  SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_SRAI, 1'b1, 4'b0000, DECODE, SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_SRAI, 1'b1, 4'b0000, EXEC_I, SB_NONE, MX_I,     ALU_SRA, 3'b000, 2'b00));
        vecs.push_back(row(I_SRAI, 1'b1, 4'b0000, ALU_WB, SB_RW,   MX_ZERO,  ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_LW, 1'b1, 4'b0000, FETCH,     SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_LW, 1'b1, 4'b0000, DECODE,    SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_LW, 1'b1, 4'b0000, MEM_ADDR,  SB_NONE, MX_I,     ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_LW, 1'b0, 4'b0000, MEM_READ,  SB_MR,   MX_ZERO,  ALU_ADD, 3'b010, 2'b00));
        vecs.push_back(row(I_LW, 1'b0, 4'b0000, MEM_READ,  SB_MR,   MX_ZERO,  ALU_ADD, 3'b010, 2'b00));
        vecs.push_back(row(I_LW, 1'b0, 4'b0000, MEM_READ,  SB_MR,   MX_ZERO,  ALU_ADD, 3'b010, 2'b00));
        vecs.push_back(row(I_LW, 1'b1, 4'b0000, MEM_READ,  SB_MR,   MX_ZERO,  ALU_ADD, 3'b010, 2'b00));
        vecs.push_back(row(I_LW, 1'b1, 4'b0000, WRITEBACK, SB_RW,   MX_WB,    ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_SW, 1'b1, 4'b0000, FETCH,     SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_SW, 1'b1, 4'b0000, DECODE,    SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_SW, 1'b1, 4'b0000, MEM_ADDR,  SB_NONE, MX_I,     ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_SW, 1'b0, 4'b0000, MEM_WRITE, SB_MW,   MX_ZERO,  ALU_ADD, 3'b010, 2'b00));
        vecs.push_back(row(I_SW, 1'b1, 4'b0000, MEM_WRITE, SB_MW,   MX_ZERO,  ALU_ADD, 3'b010, 2'b00));
        vecs.push_back(row(I_BLTU, 1'b1, 4'b0000, FETCH,  SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_BLTU, 1'b1, 4'b0000, DECODE, SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_BLTU, 1'b1, 4'b0000, BRANCH, SB_PC,   MX_R,     ALU_SUB, 3'b000, 2'b00));
        vecs.push_back(row(I_BGEU, 1'b1, 4'b0000, FETCH,  SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_BGEU, 1'b1, 4'b0000, DECODE, SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_BGEU, 1'b1, 4'b0000, BRANCH, SB_NONE, MX_R,     ALU_SUB, 3'b000, 2'b00));
        vecs.push_back(row(I_BLT, 1'b1, 4'b0110, FETCH,  SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_BLT, 1'b1, 4'b0110, DECODE, SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_BLT, 1'b1, 4'b0110, BRANCH, SB_NONE, MX_R,     ALU_SUB, 3'b000, 2'b00));
        vecs.push_back(row(I_BGE, 1'b1, 4'b0110, FETCH,  SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_BGE, 1'b1, 4'b0110, DECODE, SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_BGE, 1'b1, 4'b0110, BRANCH, SB_PC,   MX_R,     ALU_SUB, 3'b000, 2'b00));
        vecs.push_back(row(I_BEQ, 1'b1, 4'b1000, FETCH,  SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_BEQ, 1'b1, 4'b1000, DECODE, SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_BEQ, 1'b1, 4'b1000, BRANCH, SB_PC,   MX_R,     ALU_SUB, 3'b000, 2'b00));
        vecs.push_back(row(I_LUI, 1'b1, 4'b0000, FETCH,  SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_LUI, 1'b1, 4'b0000, DECODE, SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_LUI, 1'b1, 4'b0000, LUI,    SB_NONE, MX_LUI,   ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_LUI, 1'b1, 4'b0000, ALU_WB, SB_RW,   MX_ZERO,  ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_JALR, 1'b1, 4'b0000, FETCH,     SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_JALR, 1'b1, 4'b0000, DECODE,    SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_JALR, 1'b1, 4'b0000, JALR,      SB_PC,   MX_JALR,  ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_JALR, 1'b1, 4'b0000, JALR_LINK, SB_NONE, MX_LINK,  ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_JALR, 1'b1, 4'b0000, ALU_WB,    SB_RW,   MX_ZERO,  ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_JAL, 1'b1, 4'b0000, FETCH,  SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_JAL, 1'b1, 4'b0000, DECODE, SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_JAL, 1'b1, 4'b0000, JAL,    SB_PC,   MX_LINK,  ALU_ADD, 3'b000, 2'b00));
        vecs.push_back(row(I_JAL, 1'b1, 4'b0000, ALU_WB, SB_RW,   MX_ZERO,  ALU_ADD, 3'b000, 2'b00));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], "vec", i);

        // Ready arrives on the cycle the counter would hit the limit: access completes.
        for (int i = 0; i < 15; i++)
            apply(row(I_ILL, 1'b0, 4'b0000, FETCH, SB_FWT, MX_FETCH, ALU_ADD, 3'b000, 2'b00), "ready_wins", i);
        apply(row(I_ILL, 1'b1, 4'b0000, FETCH,  SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00), "ready_wins", 15);
        // Unknown opcode traps from DECODE.
        apply(row(I_ILL, 1'b1, 4'b0000, DECODE, SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00), "illegal_op", 0);
        apply(row(I_ILL, 1'b1, 4'b0000, FAULT,  SB_NONE, MX_ZERO,  ALU_ADD, 3'b000, 2'b10), "illegal_op", 1);
        apply(row(I_ADD, 1'b1, 4'b0000, FAULT,  SB_NONE, MX_ZERO,  ALU_ADD, 3'b000, 2'b10), "illegal_op", 2);
        async_reset_check("rst_illegal");

        // Reserved branch funct3: no PC write, trap.
        apply(row(I_B010, 1'b1, 4'b1000, FETCH,  SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00), "br_010", 0);
        apply(row(I_B010, 1'b1, 4'b1000, DECODE, SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00), "br_010", 1);
        apply(row(I_B010, 1'b1, 4'b1000, BRANCH, SB_NONE, MX_R,     ALU_SUB, 3'b000, 2'b00), "br_010", 2);
        apply(row(I_B010, 1'b1, 4'b1000, FAULT,  SB_NONE, MX_ZERO,  ALU_ADD, 3'b000, 2'b10), "br_010", 3);
        async_reset_check("rst_branch");

        // Load whose data never arrives: timeout inside MEM_READ.
        apply(row(I_LW, 1'b1, 4'b0000, FETCH,    SB_FRDY, MX_FETCH, ALU_ADD, 3'b000, 2'b00), "lw_to", 0);
        apply(row(I_LW, 1'b1, 4'b0000, DECODE,   SB_NONE, MX_DEC,   ALU_ADD, 3'b000, 2'b00), "lw_to", 1);
        apply(row(I_LW, 1'b1, 4'b0000, MEM_ADDR, SB_NONE, MX_I,     ALU_ADD, 3'b000, 2'b00), "lw_to", 2);
        for (int i = 0; i < 16; i++)
            apply(row(I_LW, 1'b0, 4'b0000, MEM_READ, SB_MR, MX_ZERO, ALU_ADD, 3'b010, 2'b00), "lw_to", 3 + i);
        apply(row(I_LW, 1'b0, 4'b0000, FAULT, SB_NONE, MX_ZERO, ALU_ADD, 3'b000, 2'b01), "lw_to", 19);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
